// File: rtl/fan_ctrl_pkg.sv
// Shared constants for the multi-channel fan PWM controller.
package fan_ctrl_pkg;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_CNT_BITWIDTH = 8;
    localparam int DEF_PRESCALE_DIV = 399;   // 10 MHz clk_en rate -> 25 kHz PWM count rate
    localparam int DEF_RAMP_STEP    = 4;
    localparam int DEF_WIN_PERIODS  = 1024;

    // Width of one channel's slice in the packed target/duty buses.
    localparam int DUTY_W = DEF_CNT_BITWIDTH;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int value_bits(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fan_pwm_channel.sv
// One fan channel: target latch, ramped duty, PWM compare, tach edge counting
// and the sticky stall flag.
module fan_pwm_channel
    import fan_ctrl_pkg::*;
#(
    parameter int CNT_BITWIDTH = DEF_CNT_BITWIDTH,
    parameter int RAMP_STEP    = DEF_RAMP_STEP
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    tick_i,       // shared counter advances this cycle
    input  logic                    wrap_i,       // shared counter wraps this cycle (period end)
    input  logic                    win_close_i,  // tach window closes this cycle
    input  logic [CNT_BITWIDTH:0]   cnt_next_i,   // counter value after this cycle
    input  logic [CNT_BITWIDTH-1:0] min_duty_i,
    input  logic [CNT_BITWIDTH-1:0] target_i,
    input  logic                    target_wr_i,
    input  logic                    stall_clr_i,
    input  logic                    tach_i,
    output logic                    pwm_o,
    output logic [CNT_BITWIDTH-1:0] duty_o,
    output logic                    stall_o
);

    localparam logic [CNT_BITWIDTH-1:0] STEP = CNT_BITWIDTH'(RAMP_STEP);

    logic [CNT_BITWIDTH-1:0] tgt_q, tgt_d;
    logic [CNT_BITWIDTH-1:0] duty_q, duty_d;
    logic [CNT_BITWIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                    pwm_q, pwm_d;
    logic                    stall_q, stall_d;
    logic                    sync1_q, sync2_q, sync3_q;
    logic [CNT_BITWIDTH-1:0] eff_tgt;
    logic [CNT_BITWIDTH-1:0] diff;
    logic                    rise;
    logic                    stall_set;

    // Next-state logic: ramp at period end (using the target held before any
    // same-cycle write), PWM compare on each tick, tach edge count and stall.
    always_comb begin
        tgt_d = target_wr_i ? target_i : tgt_q;

        if (tgt_q == '0)
            eff_tgt = '0;
        else if (tgt_q < min_duty_i)
            eff_tgt = min_duty_i;
        else
            eff_tgt = tgt_q;

        diff   = '0;
        duty_d = duty_q;
        if (wrap_i) begin
            if (eff_tgt == '0) begin
                duty_d = '0;
            end else if (duty_q < eff_tgt) begin
                diff   = eff_tgt - duty_q;
                duty_d = duty_q + ((diff < STEP) ? diff : STEP);
            end else if (duty_q > eff_tgt) begin
                diff   = duty_q - eff_tgt;
                duty_d = duty_q - ((diff < STEP) ? diff : STEP);
            end
        end

        // Duty above the period keeps the pin high; duty 0 keeps it low.
        pwm_d = pwm_q;
        if (tick_i)
            pwm_d = (cnt_next_i < {1'b0, duty_d});

        rise = sync2_q & ~sync3_q;

        // An edge landing on the closing cycle is credited to the new window.
        edge_cnt_d = edge_cnt_q;
        if (win_close_i)
            edge_cnt_d = CNT_BITWIDTH'(rise);
        else if (rise && (edge_cnt_q != '1))
            edge_cnt_d = edge_cnt_q + 1'b1;

        // Set wins over clear when both happen together.
        stall_set = win_close_i && (duty_q != '0) && (edge_cnt_q == '0);
        stall_d   = stall_q;
        if (stall_clr_i)
            stall_d = 1'b0;
        if (stall_set)
            stall_d = 1'b1;
    end

    // Channel state registers, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgt_q      <= '0;
            duty_q     <= '0;
            edge_cnt_q <= '0;
            pwm_q      <= 1'b0;
            stall_q    <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
        end else begin
            tgt_q      <= tgt_d;
            duty_q     <= duty_d;
            edge_cnt_q <= edge_cnt_d;
            pwm_q      <= pwm_d;
            stall_q    <= stall_d;
            sync1_q    <= tach_i;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
        end
    end

    assign pwm_o   = pwm_q;
    assign duty_o  = duty_q;
    assign stall_o = stall_q;

endmodule

// File: rtl/fan_pwm_multi.sv
// Multi-channel fan controller: shared prescaler, PWM counter and tach window,
// with one fan_pwm_channel per fan.
module fan_pwm_multi
    import fan_ctrl_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int CNT_BITWIDTH = DUTY_W,
    parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
    parameter int RAMP_STEP    = DEF_RAMP_STEP,
    parameter int WIN_PERIODS  = DEF_WIN_PERIODS
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           clk_en_i,
    input  logic [CNT_BITWIDTH:0]          period_i,
    input  logic [CNT_BITWIDTH-1:0]        min_duty_i,
    input  logic [NUM_CH*CNT_BITWIDTH-1:0] target_i,
    input  logic [NUM_CH-1:0]              target_wr_i,
    input  logic [NUM_CH-1:0]              stall_clr_i,
    input  logic [NUM_CH-1:0]              tach_i,
    output logic [NUM_CH-1:0]              pwm_o,
    output logic [NUM_CH*CNT_BITWIDTH-1:0] duty_o,
    output logic [NUM_CH-1:0]              stall_o,
    output logic                           period_end_o
);

    localparam int PW = value_bits(PRESCALE_DIV);
    localparam int WW = value_bits(WIN_PERIODS - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE_DIV);
    localparam logic [WW-1:0] WIN_MAX   = WW'(WIN_PERIODS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [CNT_BITWIDTH:0] cnt_q, cnt_d;
    logic [WW-1:0]         win_q, win_d;
    logic                  period_end_q, period_end_d;
    logic                  tick;
    logic                  wrap;
    logic                  win_close;

    // Prescaler, shared counter and window counter; all frozen while clk_en_i is low.
    // The counter compares against the live period_i, so a shorter period takes
    // effect at the next wrap and an overshooting count wraps on the next tick.
    always_comb begin
        tick    = clk_en_i && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (clk_en_i)
            presc_d = tick ? '0 : presc_q + 1'b1;

        wrap  = tick && (cnt_q >= period_i);
        cnt_d = cnt_q;
        if (tick)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;

        win_close = wrap && (win_q == WIN_MAX);
        win_d     = win_q;
        if (wrap)
            win_d = win_close ? '0 : win_q + 1'b1;

        period_end_d = wrap;
    end

    // Shared timing registers; period_end_o is the registered wrap strobe.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            win_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            period_end_q <= period_end_d;
        end
    end

    assign period_end_o = period_end_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        fan_pwm_channel #(
            .CNT_BITWIDTH (CNT_BITWIDTH),
            .RAMP_STEP    (RAMP_STEP)
        ) u_ch (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .tick_i      (tick),
            .wrap_i      (wrap),
            .win_close_i (win_close),
            .cnt_next_i  (cnt_d),
            .min_duty_i  (min_duty_i),
            .target_i    (target_i[n*CNT_BITWIDTH +: CNT_BITWIDTH]),
            .target_wr_i (target_wr_i[n]),
            .stall_clr_i (stall_clr_i[n]),
            .tach_i      (tach_i[n]),
            .pwm_o       (pwm_o[n]),
            .duty_o      (duty_o[n*CNT_BITWIDTH +: CNT_BITWIDTH]),
            .stall_o     (stall_o[n])
        );
    end

endmodule

// File: tb/tb_fan_pwm_multi.sv
// Bench for fan_pwm_multi: reset, ramp vector table, hand-written timing
// sequences, then randomized traffic against a behavioural model.
module tb_fan_pwm_multi;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               clk_en_i;
    logic [W:0]         period_i;
    logic [W-1:0]       min_duty_i;
    logic [NCH*W-1:0]   target_i;
    logic [NCH-1:0]     target_wr_i;
    logic [NCH-1:0]     stall_clr_i;
    logic [NCH-1:0]     tach_i;
    logic [NCH-1:0]     pwm_o, stall_o;
    logic [NCH*W-1:0]   duty_o;
    logic               period_end_o;
    logic [NCH-1:0]     pwm_b, stall_b;
    logic [NCH*W-1:0]   duty_b;
    logic               pe_b;

    fan_pwm_multi #(.NUM_CH(NCH), .CNT_BITWIDTH(W), .PRESCALE_DIV(0),
                    .RAMP_STEP(4), .WIN_PERIODS(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .period_i(period_i),
        .min_duty_i(min_duty_i), .target_i(target_i), .target_wr_i(target_wr_i),
        .stall_clr_i(stall_clr_i), .tach_i(tach_i), .pwm_o(pwm_o), .duty_o(duty_o),
        .stall_o(stall_o), .period_end_o(period_end_o));

    fan_pwm_multi #(.NUM_CH(NCH), .CNT_BITWIDTH(W), .PRESCALE_DIV(2),
                    .RAMP_STEP(4), .WIN_PERIODS(8)) dut_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .period_i(period_i),
        .min_duty_i(min_duty_i), .target_i(target_i), .target_wr_i(target_wr_i),
        .stall_clr_i(stall_clr_i), .tach_i(tach_i), .pwm_o(pwm_b), .duty_o(duty_b),
        .stall_o(stall_b), .period_end_o(pe_b));

    // Clock
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock, sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_pe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc();
            if (period_end_o) seen = 1'b1;
        end
        if (!seen) check("pe_timeout", 64'd0, 64'd1);
    endtask

    task automatic write_tgt(input int ch, input int v);
        target_i[ch*W +: W] = 8'(v);
        target_wr_i[ch]     = 1'b1;
        cyc();
        target_wr_i[ch]     = 1'b0;
    endtask

    // Behavioural model (prescale 0: every enabled cycle is a count tick).
    int m_cnt;
    int m_tgt  [NCH];
    int m_duty [NCH];
    bit m_pwm  [NCH];
    bit m_pe;

    function automatic void model_reset();
        m_cnt = 0;
        m_pe  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_tgt[c] = 0; m_duty[c] = 0; m_pwm[c] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        int eff, mn, per;
        mn  = int'(min_duty_i);
        per = int'(period_i);
        m_pe = 1'b0;
        if (clk_en_i) begin
            if (m_cnt >= per) begin
                m_pe  = 1'b1;
                m_cnt = 0;
                for (int c = 0; c < NCH; c++) begin
                    eff = (m_tgt[c] == 0) ? 0 : ((m_tgt[c] < mn) ? mn : m_tgt[c]);
                    if (eff == 0)               m_duty[c] = 0;
                    else if (m_duty[c] < eff)   m_duty[c] += (eff - m_duty[c] < 4) ? eff - m_duty[c] : 4;
                    else if (m_duty[c] > eff)   m_duty[c] -= (m_duty[c] - eff < 4) ? m_duty[c] - eff : 4;
                end
            end else begin
                m_cnt++;
            end
            for (int c = 0; c < NCH; c++) m_pwm[c] = (m_cnt < m_duty[c]);
        end
        for (int c = 0; c < NCH; c++)
            if (target_wr_i[c]) m_tgt[c] = int'(target_i[c*W +: W]);
    endfunction

    typedef struct {
        int tgt;
        int mind;
        int n_pe;
        int exp_duty;
    } ramp_vec_t;

    ramp_vec_t vecs [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, hi;
        bit seen;
        logic [NCH-1:0]   e_pwm;
        logic [NCH*W-1:0] e_duty;

        // ch0 ramp vectors: target, min duty, period ends to wait, expected duty
        vecs[0] = '{5,   0,  1, 4};
        vecs[1] = '{5,   0,  1, 5};
        vecs[2] = '{5,   0,  1, 5};
        vecs[3] = '{10,  30, 1, 9};
        vecs[4] = '{10,  30, 5, 29};
        vecs[5] = '{10,  30, 1, 30};
        vecs[6] = '{0,   30, 1, 0};
        vecs[7] = '{200, 0,  3, 12};
        vecs[8] = '{2,   0,  1, 8};
        vecs[9] = '{2,   0,  2, 2};

        rstn_i = 1'b0; clk_en_i = 1'b1; period_i = 9'd9; min_duty_i = '0;
        target_i = '0; target_wr_i = '0; stall_clr_i = '0; tach_i = '0;
        repeat (3) cyc();
        check("rst_pwm",   pwm_o, 0);
        check("rst_duty",  duty_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_pe",    period_end_o, 0);
        rstn_i = 1'b1;

        // Ramp table
        wait_pe();
        for (int i = 0; i < 10; i++) begin
            min_duty_i = 8'(vecs[i].mind);
            write_tgt(0, vecs[i].tgt);
            for (int k = 0; k < vecs[i].n_pe; k++) wait_pe();
            check($sformatf("ramp_vec%0d", i), duty_o[W-1:0], 64'(vecs[i].exp_duty));
            if (i == 2) begin
                hi = 0;
                for (int j = 0; j < 10; j++) begin
                    if (pwm_o[0]) hi++;
                    cyc();
                end
                check("pwm_high_5_of_10", hi, 5);
                check("pe_period_10", period_end_o, 1);
                cyc();
                check("pe_one_cycle", period_end_o, 0);
                wait_pe();
            end
        end

        // Target write on the period-end cycle still ramps toward the old target
        write_tgt(1, 40);
        wait_pe();
        check("wr_pe_first", duty_o[W +: W], 4);
        repeat (9) cyc();
        target_i[W +: W] = 8'd0; target_wr_i[1] = 1'b1;
        cyc();
        target_wr_i[1] = 1'b0;
        check("wr_pe_align", period_end_o, 1);
        check("wr_pe_old_tgt", duty_o[W +: W], 8);
        wait_pe();
        check("wr_pe_new_tgt", duty_o[W +: W], 0);

        // Stall detection on ch2
        write_tgt(2, 200);
        repeat (16) wait_pe();
        check("stall_set", stall_o[2], 1);
        check("stall_idle_ch3", stall_o[3], 0);
        stall_clr_i[2] = 1'b1; cyc(); stall_clr_i[2] = 1'b0;
        check("stall_clr", stall_o[2], 0);
        for (int p = 0; p < 20; p++) begin
            repeat (3) cyc(); tach_i[2] = 1'b1;
            repeat (3) cyc(); tach_i[2] = 1'b0;
            wait_pe();
        end
        check("stall_tach_ok", stall_o[2], 0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc();
            if (stall_o[2]) seen = 1'b1;
        end
        check("stall_reset_seen", seen, 1);
        check("stall_at_period_end", period_end_o, 1);
        stall_clr_i[2] = 1'b1; cyc(); stall_clr_i[2] = 1'b0;
        check("stall_clr2", stall_o[2], 0);
        repeat (78) cyc();
        stall_clr_i[2] = 1'b1; cyc(); stall_clr_i[2] = 1'b0;
        check("stall_set_beats_clr", stall_o[2], 1);

        // Period shortened with the counter beyond the new period
        period_i = 9'd99;
        wait_pe();
        repeat (70) cyc();
        check("pchg_no_pe_yet", period_end_o, 0);
        period_i = 9'd49;
        cyc();
        check("pchg_wrap", period_end_o, 1);
        cyc();
        check("pchg_one_pulse", period_end_o, 0);
        n = 1; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc(); n++;
            if (period_end_o) seen = 1'b1;
        end
        check("pchg_new_len", n, 50);

        // clk_en_i low freezes counter and PWM
        write_tgt(3, 20);
        repeat (5) wait_pe();
        check("frz_duty", duty_o[3*W +: W], 20);
        repeat (10) cyc();
        check("frz_pwm_before", pwm_o[3], 1);
        clk_en_i = 1'b0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (pwm_o[3] !== 1'b1 || period_end_o !== 1'b0) bad++;
        end
        check("frz_hold", bad, 0);
        clk_en_i = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc(); n++;
            if (period_end_o) seen = 1'b1;
        end
        check("frz_resume_len", n, 40);
        check("frz_duty_after", duty_o[3*W +: W], 20);

        // Prescaler 2: three clocks per count
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc();
            if (pe_b) seen = 1'b1;
        end
        n = 0; seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc(); n++;
            if (pe_b) seen = 1'b1;
        end
        check("presc_period_len", n, 150);

        // Asynchronous reset in the middle of a ramp
        write_tgt(0, 200);
        wait_pe(); wait_pe();
        check("mid_ramp_duty", duty_o[W-1:0], 10);
        #3 rstn_i = 1'b0;
        #1;
        check("async_rst_pwm",   pwm_o, 0);
        check("async_rst_duty",  duty_o, 0);
        check("async_rst_stall", stall_o, 0);
        check("async_rst_pe",    period_end_o, 0);

        // Randomized traffic against the model
        target_i = '0; target_wr_i = '0; period_i = 9'd9; min_duty_i = '0; clk_en_i = 1'b1;
        repeat (2) cyc();
        rstn_i = 1'b1;
        model_reset();
        for (int t = 0; t < 3000; t++) begin
            clk_en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) period_i = 9'($urandom_range(2, 40));
            if ($urandom_range(0, 299) == 0) min_duty_i = 8'($urandom_range(0, 20));
            target_wr_i = '0;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 59) == 0) begin
                    target_i[c*W +: W] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
                    target_wr_i[c] = 1'b1;
                end
            end
            model_step();
            cyc();
            for (int c = 0; c < NCH; c++) begin
                e_pwm[c]        = m_pwm[c];
                e_duty[c*W +: W] = 8'(m_duty[c]);
            end
            check($sformatf("rand_t%0d", t), {pwm_o, duty_o, period_end_o}, {e_pwm, e_duty, m_pe});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
